// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg: op encodings, mul/div FSM states and datapath width      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_abs_neg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | abs_neg: conditional two's-complement negate, WIDTH-generic       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module abs_neg #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_muldiv_seq: iterative signed/unsigned MUL/DIV into HI/LO      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 sgn_x_q, sgn_x_d;
  logic                 sgn_a_q, sgn_a_d;
  logic                 bz_q, bz_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 div0_q, div0_d, done_q, done_d, busy_q, busy_d;

  logic                 in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix, mul_next, div_next;
  logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;

  assign in_signed = (op == OP_MUL) || (op == OP_DIV);
  assign in_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];

  abs_neg #(.WIDTH(WIDTH))   u_abs_a   (.i_val(a), .i_neg(a_neg), .o_val(a_mag));
  abs_neg #(.WIDTH(WIDTH))   u_abs_b   (.i_val(b), .i_neg(b_neg), .o_val(b_mag));
  abs_neg #(.WIDTH(2*WIDTH)) u_fix_p   (.i_val(acc_q), .i_neg(sgn_x_q), .o_val(prod_fix));
  abs_neg #(.WIDTH(WIDTH))   u_fix_q   (.i_val(acc_q[WIDTH-1:0]), .i_neg(sgn_x_q), .o_val(quo_fix));
  abs_neg #(.WIDTH(WIDTH))   u_fix_r   (.i_val(acc_q[2*WIDTH-1:WIDTH]), .i_neg(sgn_a_q), .o_val(rem_fix));

  // acc = {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    div_next = rem_diff[WIDTH]
             ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
             : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sgn_x_d  = sgn_x_q;
    sgn_a_d  = sgn_a_q;
    bz_d     = bz_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = in_div;
          sgn_x_d  = a_neg ^ b_neg;
          sgn_a_d  = a_neg;
          bz_d     = (b == '0);
          a_raw_d  = a;
          opnd_d   = in_div ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q && bz_q) begin
          hi_d   = a_raw_q;
          lo_d   = '1;
          div0_d = 1'b1;
        end else if (is_div_q) begin
          hi_d   = rem_fix;
          lo_d   = quo_fix;
          div0_d = 1'b0;
        end else begin
          {hi_d, lo_d} = prod_fix;
          div0_d       = 1'b0;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sgn_x_q  <= 1'b0;
      sgn_a_q  <= 1'b0;
      bz_q     <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sgn_x_q  <= sgn_x_d;
      sgn_a_q  <= sgn_a_d;
      bz_q     <= bz_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_muldiv_seq: scoreboard bench for the iterative MUL/DIV unit|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W       = DATA_W;
  localparam int LATENCY = W + 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .div0 (div0),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected result per done pulse
  always @(negedge clk) begin
    if (!busy) busy_cnt = 0;
    else       busy_cnt++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", 32'(hi), 32'(mon_e.hi));
        check("lo", 32'(lo), 32'(mon_e.lo));
        check("div0", 32'(div0), 32'(mon_e.div0));
        check("latency", 32'(cyc - mon_e.issue), 32'(LATENCY));
        check("busy_cycles", 32'(busy_cnt), 32'(LATENCY));
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 4 * LATENCY; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 4 * LATENCY) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // inject > 0 pulses an unrelated start that many cycles into the operation
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic ediv0,
                        input int inject);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    e.hi = ehi; e.lo = elo; e.div0 = ediv0; e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    if (inject > 0) begin
      repeat (inject - 1) @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 16'h0005; b = 16'h0000;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic abort_op();
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 16'd100; b = 16'd7;
    @(negedge clk);
    start = 1'b0;
    // this negedge follows E0 (counter 0); eight more reach counter 8
    repeat (8) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", 32'(hi), 32'd0);
    check("abort_lo", 32'(lo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LATENCY + 4) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div0", 32'(div0), 32'd0);
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    rst_n = 1'b1;

    run_op(OP_MULU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 0);
    run_op(OP_MUL,  16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, 0);
    run_op(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 0);
    run_op(OP_MUL,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 0);
    run_op(OP_DIVU, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 0);
    run_op(OP_DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 0);
    run_op(OP_DIV,  16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 0);
    run_op(OP_DIV,  16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 0);
    run_op(OP_DIVU, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0);
    run_op(OP_MULU, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 1'b0, 0);
    run_op(OP_DIV,  16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1, 0);
    run_op(OP_MULU, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 5);
    run_op(OP_DIV,  16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 0);

    abort_op();
    run_op(OP_DIVU, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
